// File: rtl/interrupt_ctrl_if.sv
// Bus bundle between the interrupt controller, the CPU and the peripherals.
//   a/din/rd/wr/dout        : CPU register access (IF at FF0F, IE at FFFF)
//   int_req/int_ack         : peripheral level request / one-cycle ack
//   cpu_int_req/vec/ack     : interrupt offered to the CPU and its acceptance
//   wake                    : any enabled flag pending (HALT/STOP exit)
// master = CPU/peripheral side, slave = interrupt controller.
interface interrupt_ctrl_if #(
    parameter int NUM_INT = 5
);
    logic [15:0]        a;
    logic [7:0]         dout;
    logic [7:0]         din;
    logic               rd;
    logic               wr;
    logic [NUM_INT-1:0] int_req;
    logic [NUM_INT-1:0] int_ack;
    logic               cpu_int_req;
    logic [7:0]         cpu_int_vec;
    logic               cpu_int_ack;
    logic               wake;

    modport master (
        output a, din, rd, wr, int_req, cpu_int_ack,
        input  dout, int_ack, cpu_int_req, cpu_int_vec, wake
    );

    modport slave (
        input  a, din, rd, wr, int_req, cpu_int_ack,
        output dout, int_ack, cpu_int_req, cpu_int_vec, wake
    );
endinterface

// File: rtl/interrupt_ctrl.sv
// Interrupt controller. Captures rising edges of peripheral requests into IF,
// masks with IE, offers the highest-priority (lowest index) pending source to
// the CPU with its vector, and on CPU acceptance clears that IF bit and sends a
// one-cycle ack back to the peripheral.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active high
//   bus  : interrupt_ctrl_if.slave (register bus, peripheral and CPU handshakes)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | nothing offered; moves to REQ when any enabled flag pends
// REQ   | cpu_int_req high, waiting for cpu_int_ack
// ACK   | int_ack pulse to the accepted source; back to IDLE
module interrupt_ctrl #(
    parameter int         NUM_INT    = 5,
    parameter logic [7:0] VEC_BASE   = 8'h40,
    parameter logic [7:0] VEC_STRIDE = 8'h08
) (
    input  logic             clk,
    input  logic             rst,
    interrupt_ctrl_if.slave  bus
);
    localparam int IDXW = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t             state_q, state_d;
    logic [NUM_INT-1:0] if_q, if_d;
    logic [7:0]         ie_q, ie_d;
    logic [NUM_INT-1:0] prev_req_q, prev_req_d;
    logic [NUM_INT-1:0] ack_oh_q, ack_oh_d;

    logic [NUM_INT-1:0] pending;
    logic [NUM_INT-1:0] rise;
    logic [NUM_INT-1:0] idx_oh;
    logic [IDXW-1:0]    idx;
    logic               ack_take;
    logic               wr_if;
    logic               wr_ie;
    logic               unused_rd;

    // Reads do not depend on the strobe.
    assign unused_rd = bus.rd;

    assign pending  = if_q & ie_q[NUM_INT-1:0];
    assign rise     = bus.int_req & ~prev_req_q;
    assign wr_if    = bus.wr && (bus.a == 16'hFF0F);
    assign wr_ie    = bus.wr && (bus.a == 16'hFFFF);
    // An ack only counts while something is still pending to be accepted.
    assign ack_take = (state_q == REQ) && bus.cpu_int_ack && (pending != '0);

    // Lowest set bit wins: scan from the top so the last hit is the lowest.
    always_comb begin
        idx    = '0;
        idx_oh = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx = i[IDXW-1:0];
            end
        end
        idx_oh[idx] = 1'b1;
    end

    always_comb begin
        bus.cpu_int_vec = 8'h00;
        if (pending != '0) begin
            bus.cpu_int_vec = VEC_BASE + VEC_STRIDE * 8'(idx);
        end
    end

    always_comb begin
        if (bus.a == 16'hFF0F) begin
            bus.dout = {{(8 - NUM_INT){1'b1}}, if_q};
        end else if (bus.a == 16'hFFFF) begin
            bus.dout = ie_q;
        end else begin
            bus.dout = 8'hFF;
        end
    end

    assign bus.wake = |pending;

    // IF: software write, then ack clear, then new edges; an edge always wins.
    always_comb begin
        if_d = if_q;
        if (wr_if) begin
            if_d = bus.din[NUM_INT-1:0];
        end
        if (ack_take) begin
            if_d = if_d & ~idx_oh;
        end
        if_d = if_d | rise;

        ie_d = wr_ie ? bus.din : ie_q;

        // Tracks the request level even during reset so a level held across
        // reset release is not mistaken for a new edge.
        prev_req_d = bus.int_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ack_oh_q <= '0;
            if_q     <= '0;
            ie_q     <= '0;
        end else begin
            state_q  <= state_d;
            ack_oh_q <= ack_oh_d;
            if_q     <= if_d;
            ie_q     <= ie_d;
        end
        prev_req_q <= prev_req_d;
    end

    always_comb begin
        state_d  = state_q;
        ack_oh_d = '0;
        case (state_q)
            IDLE: begin
                if (pending != '0) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (pending == '0) begin
                    state_d = IDLE;
                end else if (bus.cpu_int_ack) begin
                    state_d  = ACK;
                    ack_oh_d = idx_oh;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.cpu_int_req = (state_q == REQ);
        bus.int_ack     = (state_q == ACK) ? ack_oh_q : '0;
    end
endmodule

// File: tb/tb_interrupt_ctrl.sv
module tb_interrupt_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    interrupt_ctrl_if #(.NUM_INT(5)) bus ();

    interrupt_ctrl #(
        .NUM_INT   (5),
        .VEC_BASE  (8'h40),
        .VEC_STRIDE(8'h08)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled at the negedge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [15:0] addr, input logic [7:0] data);
        bus.a   = addr;
        bus.din = data;
        bus.wr  = 1'b1;
        cyc();
        bus.wr  = 1'b0;
    endtask

    task automatic set_addr(input logic [15:0] addr);
        bus.a = addr;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        set_addr(16'hFF0F);
        checks++; if (bus.dout !== 8'hE0) begin errors++; $display("FAIL rst_if got %h exp %h", bus.dout, 8'hE0); end
        set_addr(16'hFFFF);
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL rst_ie got %h exp %h", bus.dout, 8'h00); end
        checks++; if (bus.cpu_int_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.cpu_int_req); end
        checks++; if (bus.int_ack !== 5'b0) begin errors++; $display("FAIL rst_ack got %b exp 00000", bus.int_ack); end
        checks++; if (bus.wake !== 1'b0 || bus.cpu_int_vec !== 8'h00) begin errors++; $display("FAIL rst_wake_vec got %b/%h exp 0/00", bus.wake, bus.cpu_int_vec); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        wr_reg(16'hFFFF, 8'h04);
        bus.int_req[2] = 1'b1;
        cyc();
        set_addr(16'hFF0F);
        checks++; if (bus.dout !== 8'hE4) begin errors++; $display("FAIL single_if got %h exp %h", bus.dout, 8'hE4); end
        checks++; if (bus.cpu_int_req !== 1'b0) begin errors++; $display("FAIL single_req_early got %b exp 0", bus.cpu_int_req); end
        cyc();
        checks++; if (bus.cpu_int_req !== 1'b1 || bus.cpu_int_vec !== 8'h50) begin errors++; $display("FAIL single_offer got %b/%h exp 1/50", bus.cpu_int_req, bus.cpu_int_vec); end
        bus.cpu_int_ack = 1'b1;
        cyc();
        bus.cpu_int_ack = 1'b0;
        #1;
        checks++; if (bus.int_ack !== 5'b00100) begin errors++; $display("FAIL single_ack got %b exp 00100", bus.int_ack); end
        checks++; if (bus.dout !== 8'hE0) begin errors++; $display("FAIL single_if_clr got %h exp E0", bus.dout); end
        checks++; if (bus.cpu_int_req !== 1'b0) begin errors++; $display("FAIL single_req_drop got %b exp 0", bus.cpu_int_req); end
        cyc();
        checks++; if (bus.int_ack !== 5'b00000) begin errors++; $display("FAIL single_ack_width got %b exp 00000", bus.int_ack); end
        bus.int_req[2] = 1'b0;
        cyc();
    endtask

    task automatic test_priority();
        wr_reg(16'hFFFF, 8'h1F);
        bus.int_req = 5'b00101;
        cyc();
        checks++; if (bus.cpu_int_vec !== 8'h40) begin errors++; $display("FAIL prio_vec0 got %h exp 40", bus.cpu_int_vec); end
        cyc();
        bus.cpu_int_ack = 1'b1;
        cyc();
        bus.cpu_int_ack = 1'b0;
        checks++; if (bus.int_ack !== 5'b00001) begin errors++; $display("FAIL prio_ack0 got %b exp 00001", bus.int_ack); end
        cyc();
        checks++; if (bus.cpu_int_req !== 1'b0 || bus.int_ack !== 5'b0) begin errors++; $display("FAIL prio_gap got %b/%b exp 0/00000", bus.cpu_int_req, bus.int_ack); end
        cyc();
        checks++; if (bus.cpu_int_req !== 1'b1 || bus.cpu_int_vec !== 8'h50) begin errors++; $display("FAIL prio_reoffer got %b/%h exp 1/50", bus.cpu_int_req, bus.cpu_int_vec); end
        bus.cpu_int_ack = 1'b1;
        cyc();
        bus.cpu_int_ack = 1'b0;
        set_addr(16'hFF0F);
        checks++; if (bus.int_ack !== 5'b00100) begin errors++; $display("FAIL prio_ack2 got %b exp 00100", bus.int_ack); end
        checks++; if (bus.dout !== 8'hE0) begin errors++; $display("FAIL prio_if_end got %h exp E0", bus.dout); end
        bus.int_req = 5'b0;
        cyc();
    endtask

    task automatic test_mask();
        wr_reg(16'hFFFF, 8'h00);
        bus.int_req[4] = 1'b1;
        cyc();
        cyc();
        set_addr(16'hFF0F);
        checks++; if (bus.dout !== 8'hF0) begin errors++; $display("FAIL mask_if got %h exp F0", bus.dout); end
        checks++; if (bus.wake !== 1'b0 || bus.cpu_int_req !== 1'b0) begin errors++; $display("FAIL mask_gate got %b/%b exp 0/0", bus.wake, bus.cpu_int_req); end
        bus.cpu_int_ack = 1'b1;
        cyc();
        bus.cpu_int_ack = 1'b0;
        checks++; if (bus.int_ack !== 5'b0 || bus.dout !== 8'hF0) begin errors++; $display("FAIL mask_stray_ack got %b/%h exp 00000/F0", bus.int_ack, bus.dout); end
        wr_reg(16'hFFFF, 8'h10);
        checks++; if (bus.cpu_int_req !== 1'b0 || bus.wake !== 1'b1) begin errors++; $display("FAIL mask_enable got %b/%b exp 0/1", bus.cpu_int_req, bus.wake); end
        cyc();
        checks++; if (bus.cpu_int_req !== 1'b1 || bus.cpu_int_vec !== 8'h60) begin errors++; $display("FAIL mask_offer got %b/%h exp 1/60", bus.cpu_int_req, bus.cpu_int_vec); end
        wr_reg(16'hFF0F, 8'h00);
        #1;
        checks++; if (bus.dout !== 8'hE0 || bus.int_ack !== 5'b0) begin errors++; $display("FAIL mask_wclr got %h/%b exp E0/00000", bus.dout, bus.int_ack); end
        cyc();
        checks++; if (bus.cpu_int_req !== 1'b0 || bus.int_ack !== 5'b0) begin errors++; $display("FAIL mask_withdraw got %b/%b exp 0/00000", bus.cpu_int_req, bus.int_ack); end
        bus.int_req[4] = 1'b0;
        cyc();
    endtask

    task automatic test_level_and_soft();
        wr_reg(16'hFFFF, 8'h1F);
        bus.int_req[3] = 1'b1;
        cyc();
        wr_reg(16'hFF0F, 8'h00);
        cyc();
        cyc();
        set_addr(16'hFF0F);
        checks++; if (bus.dout !== 8'hE0 || bus.cpu_int_req !== 1'b0) begin errors++; $display("FAIL level_no_reset got %h/%b exp E0/0", bus.dout, bus.cpu_int_req); end
        wr_reg(16'hFF0F, 8'h08);
        cyc();
        checks++; if (bus.cpu_int_req !== 1'b1 || bus.cpu_int_vec !== 8'h58) begin errors++; $display("FAIL soft_offer got %b/%h exp 1/58", bus.cpu_int_req, bus.cpu_int_vec); end
        bus.int_req[1] = 1'b1;
        wr_reg(16'hFF0F, 8'h00);
        set_addr(16'hFF0F);
        checks++; if (bus.dout !== 8'hE2 || bus.cpu_int_vec !== 8'h48) begin errors++; $display("FAIL rise_wins got %h/%h exp E2/48", bus.dout, bus.cpu_int_vec); end
        bus.cpu_int_ack = 1'b1;
        cyc();
        bus.cpu_int_ack = 1'b0;
        checks++; if (bus.int_ack !== 5'b00010) begin errors++; $display("FAIL rise_ack got %b exp 00010", bus.int_ack); end
        bus.int_req = 5'b0;
        cyc();
        cyc();
    endtask

    task automatic test_reset_in_req();
        bus.int_req[0] = 1'b1;
        cyc();
        cyc();
        checks++; if (bus.cpu_int_req !== 1'b1 || bus.cpu_int_vec !== 8'h40) begin errors++; $display("FAIL rreq_offer got %b/%h exp 1/40", bus.cpu_int_req, bus.cpu_int_vec); end
        rst = 1'b1;
        bus.cpu_int_ack = 1'b1;
        cyc();
        rst = 1'b0;
        bus.cpu_int_ack = 1'b0;
        set_addr(16'hFF0F);
        checks++; if (bus.dout !== 8'hE0 || bus.int_ack !== 5'b0 || bus.cpu_int_req !== 1'b0) begin errors++; $display("FAIL rreq_abort got %h/%b/%b exp E0/00000/0", bus.dout, bus.int_ack, bus.cpu_int_req); end
        set_addr(16'hFFFF);
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL rreq_ie got %h exp 00", bus.dout); end
        set_addr(16'h1234);
        checks++; if (bus.dout !== 8'hFF) begin errors++; $display("FAIL rreq_other got %h exp FF", bus.dout); end
        wr_reg(16'hFFFF, 8'h1F);
        cyc();
        set_addr(16'hFF0F);
        checks++; if (bus.dout !== 8'hE0 || bus.int_ack !== 5'b0 || bus.cpu_int_req !== 1'b0) begin errors++; $display("FAIL rreq_held_level got %h/%b/%b exp E0/00000/0", bus.dout, bus.int_ack, bus.cpu_int_req); end
        bus.int_req = 5'b0;
        cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.a = 16'h0000;
        bus.din = 8'h00;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.int_req = 5'b0;
        bus.cpu_int_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_level_and_soft();
        test_reset_in_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
